// File: rtl/shape_write_arbiter.sv
// shape_write_arbiter: round-robin arbiter that bursts one granted shape record into the shape RAM
module shape_write_arbiter #(
  parameter int NREQ  = 3,
  parameter int DATAB = 3,
  parameter int CORDW = 9,
  parameter int ADDRW = 20,
  parameter int DATAW = 12,
  parameter int NUMW  = DATAW
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*NUMW-1:0]    req_id,
  input  logic [NREQ*DATAW-1:0]   req_ty,
  input  logic [NREQ*CORDW-1:0]   req_x,
  input  logic [NREQ*CORDW-1:0]   req_y,
  input  logic [NREQ*DATAW-1:0]   req_size,
  input  logic [NREQ*DATAW-1:0]   req_rotate,
  output logic [NREQ-1:0]         grant,
  output logic [NREQ-1:0]         done,
  output logic                    busy,
  input  logic [ADDRW-1:0]        ram_address_offset,
  output logic [ADDRW-1:0]        ram_address,
  output logic                    ram_enable,
  output logic [DATAW-1:0]        ram_data
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int IW = PW + 1;
  localparam logic [1:0] IDLE = 2'd0, WRITE = 2'd1, RELEASE = 2'd2;
  logic [1:0] state;
  logic [DATAB-1:0] ptr;
  logic [PW-1:0] rr_ptr, gi, sel;
  logic [IW-1:0] idx;
  logic [NUMW-1:0] id_l;
  logic [DATAW-1:0] ty_l, size_l, rot_l;
  logic [CORDW-1:0] x_l, y_l;
  logic [31:0] p;
  // descending scan so the requester closest to rr_ptr wins
  always_comb begin
    sel = rr_ptr;
    idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = {1'b0, rr_ptr} + IW'(i);
      idx = idx >= IW'(NREQ) ? idx - IW'(NREQ) : idx;
      sel = req[idx[PW-1:0]] ? idx[PW-1:0] : sel;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      rr_ptr     <= '0;
      gi         <= '0;
      grant      <= '0;
      done       <= '0;
      ram_enable <= 1'b0;
      id_l       <= '0;
      ty_l       <= '0;
      x_l        <= '0;
      y_l        <= '0;
      size_l     <= '0;
      rot_l      <= '0;
    end else if (state == IDLE) begin
      if (|req) begin
        gi         <= sel;
        grant      <= NREQ'(1) << sel;
        id_l       <= req_id[sel*NUMW +: NUMW];
        ty_l       <= req_ty[sel*DATAW +: DATAW];
        x_l        <= req_x[sel*CORDW +: CORDW];
        y_l        <= req_y[sel*CORDW +: CORDW];
        size_l     <= req_size[sel*DATAW +: DATAW];
        rot_l      <= req_rotate[sel*DATAW +: DATAW];
        ptr        <= '0;
        ram_enable <= 1'b1;
        state      <= WRITE;
      end
    end else if (state == WRITE) begin
      ptr <= ptr + 1'b1;
      if (ptr == '1) begin
        ram_enable <= 1'b0;
        done       <= grant;
        rr_ptr     <= gi == PW'(NREQ - 1) ? '0 : gi + 1'b1;
        state      <= RELEASE;
      end
    end else begin
      done  <= '0;
      grant <= '0;
      state <= IDLE;
    end
  end
  assign busy        = state != IDLE;
  assign p           = 32'(ptr);
  assign ram_address = ram_address_offset + ADDRW'({id_l, {DATAB{1'b0}}}) + ADDRW'(ptr);
  assign ram_data    = p == 0 ? ty_l : p == 1 ? DATAW'(x_l) : p == 2 ? DATAW'(y_l) :
                       p == 3 ? size_l : p == 4 ? rot_l : '0;
endmodule

// File: tb/tb_shape_write_arbiter.sv
// tb_shape_write_arbiter: scoreboard bench for the shape RAM write arbiter
module tb_shape_write_arbiter;
  localparam int NREQ = 3, DATAB = 3, CORDW = 9, ADDRW = 20, DATAW = 12, NUMW = 12;
  logic clk = 0, rst = 1;
  logic [NREQ-1:0] req = '0;
  logic [NREQ*NUMW-1:0] req_id = '0;
  logic [NREQ*DATAW-1:0] req_ty = '0, req_size = '0, req_rotate = '0;
  logic [NREQ*CORDW-1:0] req_x = '0, req_y = '0;
  logic [NREQ-1:0] grant, done;
  logic busy, ram_enable;
  logic [ADDRW-1:0] ram_address_offset = 20'h100, ram_address;
  logic [DATAW-1:0] ram_data;
  int cyc = 0;
  int errors = 0, checks = 0;
  logic [ADDRW+DATAW-1:0] wq[$];
  int gq[$];
  logic [ADDRW+DATAW-1:0] e_w;
  int e_g;

  shape_write_arbiter #(.NREQ(NREQ), .DATAB(DATAB), .CORDW(CORDW), .ADDRW(ADDRW),
    .DATAW(DATAW), .NUMW(NUMW)) dut (
    .clk(clk), .rst(rst), .req(req), .req_id(req_id), .req_ty(req_ty), .req_x(req_x),
    .req_y(req_y), .req_size(req_size), .req_rotate(req_rotate), .grant(grant), .done(done),
    .busy(busy), .ram_address_offset(ram_address_offset), .ram_address(ram_address),
    .ram_enable(ram_enable), .ram_data(ram_data));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endfunction

  always @(negedge clk) if (!rst) begin
    if (ram_enable) begin
      if (wq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write: got addr %0h data %0h required none", ram_address, ram_data);
      end else begin
        e_w = wq.pop_front();
        check("write_addr_data", {ram_address, ram_data}, e_w);
      end
    end
    if (done != 0) begin
      if (gq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done: got %b required 0", done);
      end else begin
        e_g = gq.pop_front();
        check("done_onehot", done, 64'(1) << e_g);
        check("grant_at_done", grant, 64'(1) << e_g);
      end
    end
  end

  task automatic set_rec(input int i, input int id, input int ty, input int x, input int y,
                         input int sz, input int rot);
    req_id[i*NUMW +: NUMW]      = NUMW'(id);
    req_ty[i*DATAW +: DATAW]    = DATAW'(ty);
    req_x[i*CORDW +: CORDW]     = CORDW'(x);
    req_y[i*CORDW +: CORDW]     = CORDW'(y);
    req_size[i*DATAW +: DATAW]  = DATAW'(sz);
    req_rotate[i*DATAW +: DATAW] = DATAW'(rot);
  endtask

  task automatic expect_rec(input int g, input int id, input int ty, input int x, input int y,
                            input int sz, input int rot, input logic [ADDRW-1:0] off,
                            input int nw, input bit dn);
    logic [ADDRW-1:0] a;
    logic [DATAW-1:0] d;
    for (int w = 0; w < nw; w++) begin
      a = ADDRW'(32'(off) + 32'(id) * 8 + 32'(w));
      d = w == 0 ? DATAW'(ty) : w == 1 ? DATAW'(x) : w == 2 ? DATAW'(y) :
          w == 3 ? DATAW'(sz) : w == 4 ? DATAW'(rot) : '0;
      wq.push_back({a, d});
    end
    if (dn) gq.push_back(g);
  endtask

  task automatic wait_dones(input int n, input logic [NREQ-1:0] drop, input bit gap);
    int last, t;
    last = -1;
    t = 0;
    for (int k = 0; k < n; k++) begin
      do begin @(negedge clk); t++; end while (done == 0 && t < 300);
      if (done == 0) begin
        checks++; errors++;
        $display("FAIL done_timeout: got no done, required %0d more", n - k);
        return;
      end
      if (gap && last >= 0) check("grant_spacing", 64'(cyc - last), 10);
      last = cyc;
      req = req & ~(done & drop);
    end
  endtask

  task automatic do_reset();
    rst = 1;
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    int nb, tw, td, nw;
    repeat (3) @(negedge clk);
    check("rst_grant", grant, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_enable", ram_enable, 0);
    check("rst_addr", ram_address, 20'h100);
    ram_address_offset = 20'h234;
    #1 check("rst_addr_follow", ram_address, 20'h234);
    ram_address_offset = 20'h100;
    rst = 0;
    // single write from requester 1
    set_rec(1, 5, 2, 300, 100, 40, 3);
    expect_rec(1, 5, 2, 300, 100, 40, 3, 20'h100, 8, 1);
    @(negedge clk);
    req = 3'b010;
    nb = 0; tw = -100; td = -50;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (ram_enable) tw = t;
      if (done[1]) begin td = t; req = '0; end
      if (busy) nb++;
      else if (nb > 0) break;
    end
    check("busy_span", 64'(nb), 9);
    check("done_after_last_write", 64'(td - tw), 1);
    // contention with all three requesting
    do_reset();
    set_rec(0, 1, 10, 11, 12, 13, 14);
    set_rec(1, 2, 20, 21, 22, 23, 24);
    set_rec(2, 3, 30, 31, 32, 33, 34);
    expect_rec(0, 1, 10, 11, 12, 13, 14, 20'h100, 8, 1);
    expect_rec(1, 2, 20, 21, 22, 23, 24, 20'h100, 8, 1);
    expect_rec(2, 3, 30, 31, 32, 33, 34, 20'h100, 8, 1);
    req = 3'b111;
    wait_dones(3, 3'b111, 1);
    // fairness: 0 and 2 both held
    for (int k = 0; k < 2; k++) begin
      expect_rec(0, 1, 10, 11, 12, 13, 14, 20'h100, 8, 1);
      expect_rec(2, 3, 30, 31, 32, 33, 34, 20'h100, 8, 1);
    end
    req = 3'b101;
    wait_dones(4, 3'b000, 1);
    req = '0;
    repeat (2) @(negedge clk);
    check("idle_busy", busy, 0);
    // address wrap
    ram_address_offset = 20'hFFFF8;
    set_rec(0, 0, 7, 1, 2, 3, 4);
    expect_rec(0, 0, 7, 1, 2, 3, 4, 20'hFFFF8, 8, 1);
    req = 3'b001;
    wait_dones(1, 3'b001, 0);
    set_rec(0, 1, 7, 1, 2, 3, 4);
    expect_rec(0, 1, 7, 1, 2, 3, 4, 20'hFFFF8, 8, 1);
    req = 3'b001;
    wait_dones(1, 3'b001, 0);
    repeat (2) @(negedge clk);
    // reset in the middle of a burst
    ram_address_offset = 20'h100;
    set_rec(0, 6, 60, 61, 62, 63, 64);
    expect_rec(0, 6, 60, 61, 62, 63, 64, 20'h100, 4, 0);
    req = 3'b001;
    nw = 0;
    for (int t = 0; t < 40 && nw < 4; t++) begin
      @(negedge clk);
      if (ram_enable) nw++;
    end
    check("writes_before_rst", 64'(nw), 4);
    req = '0;
    @(posedge clk);
    #1 check("enable_before_rst", ram_enable, 1);
    #1 rst = 1;
    #1;
    check("midrst_enable", ram_enable, 0);
    check("midrst_busy", busy, 0);
    check("midrst_grant", grant, 0);
    check("midrst_done", done, 0);
    req = 3'b100;
    expect_rec(2, 3, 30, 31, 32, 33, 34, 20'h100, 8, 1);
    repeat (2) @(negedge clk);
    check("rst_hold_grant", grant, 0);
    rst = 0;
    wait_dones(1, 3'b100, 0);
    repeat (3) @(negedge clk);
    check("write_queue_empty", 64'(wq.size()), 0);
    check("grant_queue_empty", 64'(gq.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1);
  end
endmodule
